// File: rtl/ama_riscv_reg_file_sb.sv
//------------------------------------------------------------------------------
// Module   : ama_riscv_reg_file_sb
// Purpose  : Integer register file with two combinational read ports, one
//            synchronous write port, hard-wired zero at index 0, a per-register
//            pending scoreboard and a sequential post-reset clear engine.
// Options  : REG_FILE_BYPASS_EN - when defined, a write in progress is
//            forwarded to a read port addressing the same register.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ama_riscv_reg_file_sb #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   addr_d,
  input  logic [XLEN-1:0] data_d,
  input  logic [AW-1:0]   addr_a,
  input  logic [AW-1:0]   addr_b,
  output logic [XLEN-1:0] data_a,
  output logic [XLEN-1:0] data_b,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_addr,
  output logic            busy_a,
  output logic            busy_b,
  output logic            init_done
);

  localparam int         c_nregs = 1 << AW;
  localparam logic [0:0] c_init  = 1'b0;
  localparam logic [0:0] c_run   = 1'b1;

  logic [0:0]      r_state;
  logic [AW-1:0]   r_cnt;
  logic [XLEN-1:0] r_regs [c_nregs];
  logic [c_nregs-1:0] r_pending;

  logic w_run;
  logic w_wr;
  logic w_iss;

  assign w_run     = (r_state == c_run);
  assign w_wr      = w_run && we && (addr_d != '0);
  assign w_iss     = w_run && iss_en && (iss_addr != '0);
  assign init_done = w_run;

  // Control: reset restarts the clear sweep at index 1; the sweep ends on the
  // last index without wrapping the counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_init;
      r_cnt   <= AW'(1);
    end else if (r_state == c_init) begin
      if (r_cnt == AW'(c_nregs - 1)) begin
        r_state <= c_run;
      end else begin
        r_cnt <= r_cnt + AW'(1);
      end
    end
  end

  // Data storage: cleared one entry per cycle during INIT, written in RUN.
  // Index 0 is never stored to; reads of it are forced to zero below.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == c_init) begin
        r_regs[r_cnt] <= '0;
      end else if (w_wr) begin
        r_regs[addr_d] <= data_d;
      end
    end
  end

  // Scoreboard: writeback clears pending, issue sets it; issue is assigned
  // last so a same-cycle issue to the written index leaves it pending.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == c_init) begin
        r_pending[r_cnt] <= 1'b0;
      end else begin
        if (w_wr) begin
          r_pending[addr_d] <= 1'b0;
        end
        if (w_iss) begin
          r_pending[iss_addr] <= 1'b1;
        end
      end
    end
  end

  // Read port A: zero during INIT and for index 0, optional write-through.
  always_comb begin
    data_a = '0;
    busy_a = 1'b0;
    if (w_run && (addr_a != '0)) begin
      data_a = r_regs[addr_a];
      busy_a = r_pending[addr_a];
`ifdef REG_FILE_BYPASS_EN
      if (w_wr && (addr_d == addr_a)) begin
        data_a = data_d;
        busy_a = 1'b0;
      end
`endif
    end
  end

  // Read port B: identical to port A, fully independent.
  always_comb begin
    data_b = '0;
    busy_b = 1'b0;
    if (w_run && (addr_b != '0)) begin
      data_b = r_regs[addr_b];
      busy_b = r_pending[addr_b];
`ifdef REG_FILE_BYPASS_EN
      if (w_wr && (addr_d == addr_b)) begin
        data_b = data_d;
        busy_b = 1'b0;
      end
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ama_riscv_reg_file_sb.sv
//------------------------------------------------------------------------------
// Module   : tb_ama_riscv_reg_file_sb
// Purpose  : Scoreboard bench for ama_riscv_reg_file_sb. Stimulus pushes the
//            expected outputs of each checked cycle; a monitor pops and
//            compares them on the falling edge.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ama_riscv_reg_file_sb;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic            clk;
  logic            rst;
  logic            we;
  logic [AW-1:0]   addr_d;
  logic [XLEN-1:0] data_d;
  logic [AW-1:0]   addr_a;
  logic [AW-1:0]   addr_b;
  logic [XLEN-1:0] data_a;
  logic [XLEN-1:0] data_b;
  logic            iss_en;
  logic [AW-1:0]   iss_addr;
  logic            busy_a;
  logic            busy_b;
  logic            init_done;

  ama_riscv_reg_file_sb #(.XLEN(XLEN), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .addr_d    (addr_d),
    .data_d    (data_d),
    .addr_a    (addr_a),
    .addr_b    (addr_b),
    .data_a    (data_a),
    .data_b    (data_b),
    .iss_en    (iss_en),
    .iss_addr  (iss_addr),
    .busy_a    (busy_a),
    .busy_b    (busy_b),
    .init_done (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [XLEN-1:0] da;
    logic [XLEN-1:0] db;
    logic            ba;
    logic            bb;
    logic            done;
  } exp_t;

  exp_t  q_exp [$];
  string q_name [$];
  int    errors = 0;
  int    checks = 0;

  // Push the expected outputs for the current cycle.
  task automatic chk(input string name, input logic [XLEN-1:0] da,
                     input logic [XLEN-1:0] db, input logic ba,
                     input logic bb, input logic done);
    exp_t e;
    e.da = da; e.db = db; e.ba = ba; e.bb = bb; e.done = done;
    q_exp.push_back(e);
    q_name.push_back(name);
  endtask

  // Advance one edge; inputs are changed 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; iss_en = 1'b0; addr_d = '0; data_d = '0; iss_addr = '0;
  endtask

  // Monitor: compares every queued expectation against the DUT mid-cycle.
  always @(negedge clk) begin
    while (q_exp.size() > 0) begin
      exp_t  e;
      string n;
      e = q_exp.pop_front();
      n = q_name.pop_front();
      checks++;
      if (data_a !== e.da || data_b !== e.db || busy_a !== e.ba ||
          busy_b !== e.bb || init_done !== e.done) begin
        errors++;
        $display("FAIL %s: got a=%h b=%h ba=%b bb=%b done=%b, want a=%h b=%h ba=%b bb=%b done=%b",
                 n, data_a, data_b, busy_a, busy_b, init_done,
                 e.da, e.db, e.ba, e.bb, e.done);
      end
    end
  end

  // Pulse reset for one edge, then expect exactly 31 cycles with init_done=0
  // and zero outputs; optional we/iss pulses late in INIT must be dropped.
  task automatic reset_seq(input string name, input bit poke);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 31; i++) begin
      idle();
      if (poke && i == 29) begin
        we = 1'b1; addr_d = 5'd2; data_d = 32'hBAD0_BAD0;
        iss_en = 1'b1; iss_addr = 5'd3;
      end
      if (poke && i == 30) begin
        we = 1'b1; addr_d = 5'd4; data_d = 32'hBAD0_0004;
        iss_en = 1'b1; iss_addr = 5'd4;
      end
      chk(name, '0, '0, 1'b0, 1'b0, 1'b0);
      step();
    end
    idle();
  endtask

  initial begin
    rst = 1'b1; idle(); addr_a = 5'd5; addr_b = 5'd5;
    step();
    chk("reset_state", '0, '0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 31; i++) step();
    chk("init_done_first", '0, '0, 1'b0, 1'b0, 1'b1);

    // Preload x5, then reset must clear it.
    we = 1'b1; addr_d = 5'd5; data_d = 32'hDEAD_BEEF;
    step();
    idle();
    chk("preload_x5", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1);
    step();
    reset_seq("clear_init", 1'b0);
    chk("x5_cleared", '0, '0, 1'b0, 1'b0, 1'b1);
    step();

    // Write x7 and attempt to write x0.
    we = 1'b1; addr_d = 5'd7; data_d = 32'h1234_5678;
    step();
    addr_d = 5'd0; data_d = 32'hFFFF_FFFF;
    step();
    idle();
    addr_a = 5'd7; addr_b = 5'd0;
    chk("x7_and_x0", 32'h1234_5678, '0, 1'b0, 1'b0, 1'b1);
    step();

    // Issue x9: busy only from the next cycle.
    iss_en = 1'b1; iss_addr = 5'd9; addr_a = 5'd9; addr_b = 5'd7;
    chk("issue_cycle", '0, 32'h1234_5678, 1'b0, 1'b0, 1'b1);
    step();
    idle();
    chk("busy_after_issue", '0, 32'h1234_5678, 1'b1, 1'b0, 1'b1);
    step();

    // Writeback x9.
    we = 1'b1; addr_d = 5'd9; data_d = 32'hA5A5_A5A5; addr_b = 5'd9;
`ifdef REG_FILE_BYPASS_EN
    chk("wb_cycle", 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0, 1'b0, 1'b1);
`else
    chk("wb_cycle", '0, '0, 1'b1, 1'b1, 1'b1);
`endif
    step();
    idle();
    chk("wb_after", 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0, 1'b0, 1'b1);
    step();

    // Write and issue x3 together: the issue wins the pending bit.
    we = 1'b1; addr_d = 5'd3; data_d = 32'h1;
    iss_en = 1'b1; iss_addr = 5'd3; addr_a = 5'd3; addr_b = 5'd0;
`ifdef REG_FILE_BYPASS_EN
    chk("collision_cycle", 32'h1, '0, 1'b0, 1'b0, 1'b1);
`else
    chk("collision_cycle", '0, '0, 1'b0, 1'b0, 1'b1);
`endif
    step();
    idle();
    chk("collision_after", 32'h1, '0, 1'b1, 1'b0, 1'b1);
    step();

    // Issue to x0 is discarded.
    iss_en = 1'b1; iss_addr = 5'd0; addr_a = 5'd0; addr_b = 5'd3;
    step();
    idle();
    chk("x0_never_busy", '0, 32'h1, 1'b0, 1'b1, 1'b1);
    step();

    // Fill x1..x31 and mark x4 pending.
    for (int i = 1; i < 32; i++) begin
      we = 1'b1; addr_d = 5'(i); data_d = 32'h1000_0000 + 32'(i);
      step();
    end
    idle();
    iss_en = 1'b1; iss_addr = 5'd4;
    step();
    idle();
    addr_a = 5'd4; addr_b = 5'd31;
    chk("filled", 32'h1000_0004, 32'h1000_001F, 1'b1, 1'b0, 1'b1);
    step();

    // Mid-operation reset with pulses during INIT.
    reset_seq("mid_reset_init", 1'b1);
    for (int i = 0; i < 32; i++) begin
      addr_a = 5'(i); addr_b = 5'(31 - i);
      chk("all_clear", '0, '0, 1'b0, 1'b0, 1'b1);
      step();
    end

    @(negedge clk);
    #1;
    if (q_exp.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d unchecked entries, want 0", q_exp.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ama_riscv_reg_file_sb.md
# ama_riscv_reg_file_sb

Parametrised integer register file for the AMA-RISCV core: two asynchronous read ports, one synchronous write port, a hard-wired zero register, a per-register pending scoreboard and a sequential clear engine that zeroes one register per cycle after reset. It sits between decode (read and issue) and writeback (write) and lets the hazard unit stall on busy operands without keeping its own tracking state.

## Interface
- XLEN, 32, data width in bits
- AW, 5, address width; NREGS = 2**AW registers, index 0 hard-wired to zero
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- we  in  1  writeback enable
- addr_d  in  AW  writeback register index
- data_d  in  XLEN  writeback data
- addr_a  in  AW  read port A index
- addr_b  in  AW  read port B index
- data_a  out  XLEN  read port A data, combinational
- data_b  out  XLEN  read port B data, combinational
- iss_en  in  1  issue of an instruction that will write iss_addr
- iss_addr  in  AW  destination index of the issued instruction
- busy_a  out  1  addr_a has an outstanding write, combinational
- busy_b  out  1  addr_b has an outstanding write, combinational
- init_done  out  1  clear sequence finished, file usable

## Operation
- State machine: INIT, RUN. rst high at an edge -> INIT with clear counter cnt = 1. This holds regardless of current state, so reset mid-operation restarts the clear.
- INIT, rst low: each edge zeroes reg[cnt] and pending[cnt], then increments cnt. The edge that clears index NREGS-1 moves the state to RUN. The counter is AW bits wide and never wraps past NREGS-1.
- INIT: we and iss_en are ignored, data_a, data_b, busy_a and busy_b read 0, and init_done = 0.
- RUN: init_done = 1.
- Write in RUN: we=1 and addr_d != 0 -> reg[addr_d] <= data_d and pending[addr_d] <= 0.
- Issue in RUN: iss_en=1 and iss_addr != 0 -> pending[iss_addr] <= 1.
- Write and issue in the same cycle to the same index: data is written and pending ends at 1, because the newer producer wins.
- Index 0: writes and issues are discarded, reads return 0, busy is always 0.
- Read, addr_x != 0: data_x = reg[addr_x] and busy_x = pending[addr_x]. Both ports are independent and may alias each other and addr_d.
- Reset values, valid after the first rst edge: init_done=0, data_a=data_b=0, busy_a=busy_b=0, state=INIT.

## Timing
- Read latency: 0 cycles, combinational from addr_x, and from the write port when bypass is enabled.
- Write latency: 1 edge.
- Issue-to-busy: 1 edge; busy is visible in the cycle after iss_en.
- Init latency: exactly NREGS-1 edges with rst low, 31 for AW=5. init_done rises after the last of them. Holding rst high keeps the block in INIT with cnt=1.
- No handshake is provided. Consumers must not issue or write until init_done=1, because inputs during INIT are dropped.

## Configuration
- REG_FILE_BYPASS_EN defined, RUN state only:
  - When we=1 and addr_d == addr_x != 0, data_x = data_d and busy_x = 0 in the same cycle (write-through).
  - Bypass never applies to index 0 or during INIT.
- REG_FILE_BYPASS_EN undefined: reads always return the stored value, so a write becomes visible on the cycle after its edge. busy_x stays 1 during the writeback cycle and clears after the edge.

## Test plan
- Reset and clear: preload reg5 = 0xDEADBEEF, then pulse rst for 1 cycle. Expect init_done=0 for exactly 31 edges, then 1. After that, reading addr_a=5 returns 0x00000000 with busy_a=0.
- Write and x0: write 0x12345678 to x7 and 0xFFFFFFFF to x0. Then addr_a=7 returns 0x12345678 and addr_b=0 returns 0x00000000.
- Scoreboard:
  - iss_en with iss_addr=9 gives busy_a=1 for addr_a=9 from the next cycle.
  - A write of 0xA5A5A5A5 to x9 gives busy_a=0 and data 0xA5A5A5A5 after the edge.
  - With bypass enabled, both are visible during the write cycle.
- Collision: in one cycle, we to x3 = 0x1 and iss_en to x3. Next cycle expect reg3 = 0x1 and busy=1.
- Mid-operation reset: with x1..x31 written and x4 pending, assert rst for 1 cycle.
  - Immediately after, both ports read 0 and both busy outputs are 0 for 31 cycles.
  - After init_done, all registers read 0 and none are busy.
  - We and iss_en pulses during INIT have no effect.
